// File: rtl/chroni_vram_arbiter_if.sv
// Bus bundle between chroni, the CPU and the shared video RAM port.
// The arbiter takes the slave view; the requesters/RAM side takes the master view.
interface chroni_vram_arbiter_if;
    logic [12:0] vid_addr;
    logic        vid_rd_req;
    logic        vid_rd_ack;
    logic [7:0]  vid_data;

    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_we;
    logic        cpu_req;
    logic        cpu_ack;
    logic [7:0]  cpu_rd_data;

    logic [12:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wr_data;
    logic [7:0]  mem_rd_data;

    modport slave (
        input  vid_addr, vid_rd_req,
        input  cpu_addr, cpu_wr_data, cpu_we, cpu_req,
        input  mem_rd_data,
        output vid_rd_ack, vid_data,
        output cpu_ack, cpu_rd_data,
        output mem_addr, mem_we, mem_wr_data
    );

    modport master (
        output vid_addr, vid_rd_req,
        output cpu_addr, cpu_wr_data, cpu_we, cpu_req,
        output mem_rd_data,
        input  vid_rd_ack, vid_data,
        input  cpu_ack, cpu_rd_data,
        input  mem_addr, mem_we, mem_wr_data
    );
endinterface

// File: rtl/chroni_vram_arbiter.sv
// Video-priority arbiter for the shared 8 KB chroni video RAM port (fixed-latency sync RAM).
// Optional macro VRAM_ARB_FAIRNESS_EN: grant the CPU after VID_BURST_MAX video grants while it waits.
module chroni_vram_arbiter #(
    parameter int MEM_LATENCY   = 1,
    parameter int VID_BURST_MAX = 4
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    chroni_vram_arbiter_if.slave  bus,
    output logic                  busy
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    // WAIT counts down to zero; its last cycle is the one where read data is valid.
    localparam logic [1:0] WAIT_INIT = 2'(MEM_LATENCY - 1);

    logic [1:0]  state_reg, state_next;
    logic        owner_vid_reg, owner_vid_next;
    logic        write_reg, write_next;
    logic [1:0]  wait_cnt_reg, wait_cnt_next;
    logic [12:0] mem_addr_reg, mem_addr_next;
    logic        mem_we_reg, mem_we_next;
    logic [7:0]  mem_wr_data_reg, mem_wr_data_next;
    logic [7:0]  vid_data_reg, vid_data_next;
    logic [7:0]  cpu_rd_data_reg, cpu_rd_data_next;
    logic        vid_ack_reg, vid_ack_next;
    logic        cpu_ack_reg, cpu_ack_next;

    logic        cpu_turn;
    logic        grant_vid;
    logic        grant_cpu;

`ifdef VRAM_ARB_FAIRNESS_EN
    logic [2:0]  burst_cnt_reg, burst_cnt_next;

    assign cpu_turn = bus.cpu_req && (burst_cnt_reg == 3'(VID_BURST_MAX));

    // Counts video grants that overtook a waiting CPU; any CPU grant or idle CPU clears it.
    always_comb begin
        burst_cnt_next = burst_cnt_reg;
        if (state_reg == ST_IDLE) begin
            if (grant_cpu || !bus.cpu_req) begin
                burst_cnt_next = 3'd0;
            end else if (grant_vid) begin
                burst_cnt_next = burst_cnt_reg + 3'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt_reg <= 3'd0;
        end else begin
            burst_cnt_reg <= burst_cnt_next;
        end
    end
`else
    logic unused_burst_cfg;

    assign cpu_turn         = 1'b0;
    assign unused_burst_cfg = (VID_BURST_MAX != 0);
`endif

    assign grant_vid = bus.vid_rd_req && !cpu_turn;
    assign grant_cpu = bus.cpu_req && (!bus.vid_rd_req || cpu_turn);

    always_comb begin
        state_next       = state_reg;
        owner_vid_next   = owner_vid_reg;
        write_next       = write_reg;
        wait_cnt_next    = wait_cnt_reg;
        mem_addr_next    = mem_addr_reg;
        mem_we_next      = 1'b0;
        mem_wr_data_next = mem_wr_data_reg;
        vid_data_next    = vid_data_reg;
        cpu_rd_data_next = cpu_rd_data_reg;
        vid_ack_next     = 1'b0;
        cpu_ack_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // The memory port is loaded at grant so it is already valid in ISSUE.
                if (grant_vid) begin
                    state_next     = ST_ISSUE;
                    owner_vid_next = 1'b1;
                    write_next     = 1'b0;
                    mem_addr_next  = bus.vid_addr;
                end else if (grant_cpu) begin
                    state_next     = ST_ISSUE;
                    owner_vid_next = 1'b0;
                    write_next     = bus.cpu_we;
                    mem_addr_next  = bus.cpu_addr;
                    mem_we_next    = bus.cpu_we;
                    if (bus.cpu_we) begin
                        mem_wr_data_next = bus.cpu_wr_data;
                    end
                end
            end
            ST_ISSUE: begin
                if (write_reg) begin
                    state_next   = ST_ACK;
                    cpu_ack_next = 1'b1;
                end else begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == 2'd0) begin
                    state_next = ST_ACK;
                    if (owner_vid_reg) begin
                        vid_data_next = bus.mem_rd_data;
                        vid_ack_next  = 1'b1;
                    end else begin
                        cpu_rd_data_next = bus.mem_rd_data;
                        cpu_ack_next     = 1'b1;
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg - 2'd1;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            owner_vid_reg   <= 1'b0;
            write_reg       <= 1'b0;
            wait_cnt_reg    <= 2'd0;
            mem_addr_reg    <= 13'd0;
            mem_we_reg      <= 1'b0;
            mem_wr_data_reg <= 8'd0;
            vid_data_reg    <= 8'd0;
            cpu_rd_data_reg <= 8'd0;
            vid_ack_reg     <= 1'b0;
            cpu_ack_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            owner_vid_reg   <= owner_vid_next;
            write_reg       <= write_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_addr_reg    <= mem_addr_next;
            mem_we_reg      <= mem_we_next;
            mem_wr_data_reg <= mem_wr_data_next;
            vid_data_reg    <= vid_data_next;
            cpu_rd_data_reg <= cpu_rd_data_next;
            vid_ack_reg     <= vid_ack_next;
            cpu_ack_reg     <= cpu_ack_next;
        end
    end

    assign bus.mem_addr    = mem_addr_reg;
    assign bus.mem_we      = mem_we_reg;
    assign bus.mem_wr_data = mem_wr_data_reg;
    assign bus.vid_rd_ack  = vid_ack_reg;
    assign bus.vid_data    = vid_data_reg;
    assign bus.cpu_ack     = cpu_ack_reg;
    assign bus.cpu_rd_data = cpu_rd_data_reg;
    assign busy            = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_chroni_vram_arbiter.sv
// Directed bench: two arbiters (MEM_LATENCY 1 and 3), each with a behavioural sync RAM.
// Cycle n below means "n rising edges after the request was raised", sampled 1 ns after the edge.
module tb_chroni_vram_arbiter;
    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy0;
    logic busy3;

    int checks = 0;
    int errors = 0;

    chroni_vram_arbiter_if bus0 ();
    chroni_vram_arbiter_if bus3 ();

    chroni_vram_arbiter #(.MEM_LATENCY(1), .VID_BURST_MAX(4)) dut0 (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus0),
        .busy    (busy0)
    );

    chroni_vram_arbiter #(.MEM_LATENCY(3), .VID_BURST_MAX(4)) dut3 (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus3),
        .busy    (busy3)
    );

    always #5 sys_clk = ~sys_clk;

    // Synchronous RAMs: one registered stage for latency 1, three for latency 3.
    logic [7:0]  ram0 [0:8191];
    logic [7:0]  ram3 [0:8191];
    logic [7:0]  rd0_q;
    logic [7:0]  rd3_q [0:2];
    logic        pl_we   = 1'b0;
    logic [12:0] pl_addr = 13'd0;
    logic [7:0]  pl_data = 8'd0;

    always @(posedge sys_clk) begin
        if (pl_we) begin
            ram0[pl_addr] <= pl_data;
            ram3[pl_addr] <= pl_data;
        end
        if (bus0.mem_we) ram0[bus0.mem_addr] <= bus0.mem_wr_data;
        if (bus3.mem_we) ram3[bus3.mem_addr] <= bus3.mem_wr_data;
        rd0_q    <= ram0[bus0.mem_addr];
        rd3_q[0] <= ram3[bus3.mem_addr];
        rd3_q[1] <= rd3_q[0];
        rd3_q[2] <= rd3_q[1];
    end

    assign bus0.mem_rd_data = rd0_q;
    assign bus3.mem_rd_data = rd3_q[2];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [12:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        tick();
        pl_we   = 1'b0;
    endtask

    task automatic cpu_xact(input logic we, input logic [12:0] a, input logic [7:0] d,
                            input int exp_lat, input string tag);
        int ack_at = -1;
        int we_cnt = 0;
        bus0.cpu_addr    = a;
        bus0.cpu_wr_data = d;
        bus0.cpu_we      = we;
        bus0.cpu_req     = 1'b1;
        for (int n = 1; n <= 12 && ack_at < 0; n++) begin
            tick();
            if (n == 1) begin
                check({tag, " mem_addr"}, 32'(bus0.mem_addr), 32'(a));
                check({tag, " busy"}, 32'(busy0), 1);
            end
            if (bus0.mem_we) we_cnt++;
            if (bus0.cpu_ack) begin
                ack_at       = n;
                bus0.cpu_req = 1'b0;
                bus0.cpu_addr = 13'h1FFF;
            end
        end
        check({tag, " ack cycle"}, ack_at, exp_lat);
        check({tag, " mem_we cycles"}, we_cnt, we ? 1 : 0);
        tick();
        check({tag, " ack width"}, 32'(bus0.cpu_ack), 0);
        $display("cpu %s we=%0d addr=%h ack@%0d rd_data=%h", tag, we, a, ack_at, bus0.cpu_rd_data);
    endtask

    task automatic vid_xact(input logic [12:0] a, input int exp_lat, input logic [7:0] exp_d,
                            input string tag);
        int ack_at = -1;
        bus0.vid_addr   = a;
        bus0.vid_rd_req = 1'b1;
        for (int n = 1; n <= 12 && ack_at < 0; n++) begin
            tick();
            if (n == 1) check({tag, " mem_addr"}, 32'(bus0.mem_addr), 32'(a));
            check({tag, " mem_we"}, 32'(bus0.mem_we), 0);
            if (bus0.vid_rd_ack) begin
                ack_at          = n;
                bus0.vid_rd_req = 1'b0;
                bus0.vid_addr   = 13'h1FFF;
            end
        end
        check({tag, " ack cycle"}, ack_at, exp_lat);
        check({tag, " vid_data"}, 32'(bus0.vid_data), 32'(exp_d));
        tick();
        check({tag, " ack width"}, 32'(bus0.vid_rd_ack), 0);
        tick();
        check({tag, " data hold"}, 32'(bus0.vid_data), 32'(exp_d));
        $display("vid %s addr=%h ack@%0d data=%h", tag, a, ack_at, bus0.vid_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int v_at;
        int c_at;
        int vcnt;
        int ccnt;
        logic [9:0] order;

        bus0.vid_addr = 13'd0; bus0.vid_rd_req = 1'b0;
        bus0.cpu_addr = 13'd0; bus0.cpu_wr_data = 8'd0; bus0.cpu_we = 1'b0; bus0.cpu_req = 1'b0;
        bus3.vid_addr = 13'd0; bus3.vid_rd_req = 1'b0;
        bus3.cpu_addr = 13'd0; bus3.cpu_wr_data = 8'd0; bus3.cpu_we = 1'b0; bus3.cpu_req = 1'b0;

        // Reset state, with the RAMs preloaded while the arbiters are held.
        preload(13'h0000, 8'h11);
        preload(13'h0402, 8'h41);
        preload(13'h0155, 8'h77);
        check("rst busy0", 32'(busy0), 0);
        check("rst busy3", 32'(busy3), 0);
        check("rst acks", {30'd0, bus0.vid_rd_ack, bus0.cpu_ack}, 0);
        check("rst mem_we", 32'(bus0.mem_we), 0);
        check("rst mem_addr", 32'(bus0.mem_addr), 0);
        check("rst mem_wr_data", 32'(bus0.mem_wr_data), 0);
        check("rst vid_data", 32'(bus0.vid_data), 0);
        check("rst cpu_rd_data", 32'(bus0.cpu_rd_data), 0);
        $display("reset checked");
        reset_n = 1'b1;
        tick();

        // CPU write then read-back.
        cpu_xact(1'b1, 13'h0401, 8'h5A, 2, "wr1");
        check("wr1 rd_data untouched", 32'(bus0.cpu_rd_data), 0);
        check("wr1 mem_wr_data", 32'(bus0.mem_wr_data), 32'h5A);
        cpu_xact(1'b0, 13'h0401, 8'h00, 3, "rd1");
        check("rd1 cpu_rd_data", 32'(bus0.cpu_rd_data), 32'h5A);
        cpu_xact(1'b1, 13'h0403, 8'hC3, 2, "wr2");
        check("wr2 rd_data untouched", 32'(bus0.cpu_rd_data), 32'h5A);

        // Video read of preloaded data.
        vid_xact(13'h0402, 3, 8'h41, "vrd1");
        check("vrd1 cpu data untouched", 32'(bus0.cpu_rd_data), 32'h5A);

        // Simultaneous requests: video first, CPU re-arbitrated after ACK.
        bus0.vid_addr = 13'h0402; bus0.vid_rd_req = 1'b1;
        bus0.cpu_addr = 13'h0403; bus0.cpu_we = 1'b0; bus0.cpu_req = 1'b1;
        v_at = -1;
        c_at = -1;
        for (int n = 1; n <= 16 && c_at < 0; n++) begin
            tick();
            if (bus0.vid_rd_ack) begin v_at = n; bus0.vid_rd_req = 1'b0; end
            if (bus0.cpu_ack)    begin c_at = n; bus0.cpu_req = 1'b0; end
        end
        check("both vid ack cycle", v_at, 3);
        check("both cpu ack cycle", c_at, 7);
        check("both vid_data", 32'(bus0.vid_data), 32'h41);
        check("both cpu_rd_data", 32'(bus0.cpu_rd_data), 32'hC3);
        $display("simultaneous vid ack@%0d cpu ack@%0d", v_at, c_at);
        tick();

        // Continuous video with a pending CPU.
        bus0.vid_addr = 13'h0402; bus0.vid_rd_req = 1'b1;
        bus0.cpu_addr = 13'h0403; bus0.cpu_we = 1'b0; bus0.cpu_req = 1'b1;
        vcnt  = 0;
        ccnt  = 0;
        order = '0;
`ifdef VRAM_ARB_FAIRNESS_EN
        for (int n = 0; n < 600 && (vcnt + ccnt) < 10; n++) begin
`else
        for (int n = 0; n < 600 && (vcnt + ccnt) < 100; n++) begin
`endif
            tick();
            if (bus0.vid_rd_ack || bus0.cpu_ack) begin
                order = {bus0.cpu_ack, order[9:1]};
                if (bus0.cpu_ack) ccnt++;
                else vcnt++;
            end
        end
        bus0.vid_rd_req = 1'b0;
        bus0.cpu_req    = 1'b0;
`ifdef VRAM_ARB_FAIRNESS_EN
        check("fair grant order", 32'(order), 32'h210);
        check("fair cpu grants", ccnt, 2);
`else
        check("strict vid grants", vcnt, 100);
        check("strict cpu grants", ccnt, 0);
`endif
        $display("burst run vid=%0d cpu=%0d order=%b", vcnt, ccnt, order);
        tick();
        tick();
        check("burst end idle", 32'(busy0), 0);

        // Reset during WAIT of a CPU read.
        bus0.cpu_addr = 13'h0403; bus0.cpu_we = 1'b0; bus0.cpu_req = 1'b1;
        tick();
        tick();
        check("rstw in flight", 32'(busy0), 1);
        reset_n = 1'b0;
        #1;
        check("rstw busy", 32'(busy0), 0);
        check("rstw cpu_rd_data", 32'(bus0.cpu_rd_data), 0);
        check("rstw vid_data", 32'(bus0.vid_data), 0);
        check("rstw mem_addr", 32'(bus0.mem_addr), 0);
        bus0.cpu_req = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("rstw acks", {30'd0, bus0.vid_rd_ack, bus0.cpu_ack}, 0);
        end
        $display("reset during WAIT checked");
        reset_n = 1'b1;
        tick();
        cpu_xact(1'b0, 13'h0403, 8'h00, 3, "rd_after_rst");
        check("rd_after_rst data", 32'(bus0.cpu_rd_data), 32'hC3);

        // Latency-3 build: ack 5 cycles after req, data from the third cycle after mem_addr.
        bus3.vid_addr   = 13'h0155;
        bus3.vid_rd_req = 1'b1;
        v_at = -1;
        for (int n = 1; n <= 12 && v_at < 0; n++) begin
            tick();
            if (bus3.vid_rd_ack) begin v_at = n; bus3.vid_rd_req = 1'b0; end
        end
        check("lat3 ack cycle", v_at, 5);
        check("lat3 vid_data", 32'(bus3.vid_data), 32'h77);
        tick();
        check("lat3 ack width", 32'(bus3.vid_rd_ack), 0);
        $display("lat3 vid addr=0155 ack@%0d data=%h", v_at, bus3.vid_data);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
